vl6180x_seq: RTL

//  Register-level sequencer for the VL6180X ToF sensor; sits directly upstream of i2c_master.

---
 rtl/vl6180x_seq.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vl6180x_seq.sv
// vl6180x_seq - register-level sequencer for the VL6180X time-of-flight sensor.
//
// Sits directly upstream of i2c_master. It issues one register read or write
// per command over a valid/ready handshake and waits for that command's
// response before issuing the next one.
// Sequence: boot wait, optional init table, then continuous single-shot
// ranging. Each range result (mm) is published with a one-cycle strobe.
//
// Optional feature macro: VL6180X_SEQ_INIT_EN
//   defined   : after boot, an 8-entry init register table is written.
//   undefined : no init phase; boot goes straight to clearing the fresh-out-of-reset flag.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   CMD_VALID/CMD_READY  command handshake towards i2c_master
//   CMD_ADDR             7-bit device address
//   CMD_RW               1 = read, 0 = write
//   CMD_REG              16-bit register index
//   CMD_WDATA            write data (0 for reads)
//   RSP_VALID            one-cycle pulse when a transaction has finished
//   RSP_NACK, RSP_DATA   response status and read byte, qualified by RSP_VALID
//   RANGE, RANGE_VALID   last range in mm, and its one-cycle update strobe
//   ERROR                high while in the error back-off state
module vl6180x_seq #(
    parameter logic [6:0] DEV_ADDR   = 7'h29,
    parameter int         POLL_GAP   = 12_000,
    parameter int         RETRY_WAIT = 120_000,
    parameter int         POLL_MAX   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [6:0]  CMD_ADDR,
    output logic        CMD_RW,
    output logic [15:0] CMD_REG,
    output logic [7:0]  CMD_WDATA,
    input  logic        RSP_VALID,
    input  logic        RSP_NACK,
    input  logic [7:0]  RSP_DATA,
    output logic [7:0]  RANGE,
    output logic        RANGE_VALID,
    output logic        ERROR
);

    localparam int GAP_W  = (POLL_GAP   > 0) ? $clog2(POLL_GAP + 1)   : 1;
    localparam int ERR_W  = (RETRY_WAIT > 0) ? $clog2(RETRY_WAIT + 1) : 1;
    localparam int POLL_W = (POLL_MAX   > 0) ? $clog2(POLL_MAX + 1)   : 1;

    // Terminal counts are "last cycle index" values so each wait lasts exactly N cycles.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP   > 0) ? POLL_GAP - 1   : 0);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'((RETRY_WAIT > 0) ? RETRY_WAIT - 1 : 0);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'((POLL_MAX  > 0) ? POLL_MAX - 1   : 0);

    typedef enum logic [3:0] {
        ST_BOOT, ST_INIT, ST_CLRF, ST_START, ST_POLL, ST_READ, ST_CLR, ST_GAP, ST_ERR
    } state_t;

    // Command word layout: {rw, reg[15:0], wdata[7:0]}
    function automatic logic [24:0] cmd_for(input state_t s);
        case (s)
            ST_BOOT:  cmd_for = {1'b1, 16'h0016, 8'h00};
            ST_CLRF:  cmd_for = {1'b0, 16'h0016, 8'h00};
            ST_START: cmd_for = {1'b0, 16'h0018, 8'h01};
            ST_POLL:  cmd_for = {1'b1, 16'h004F, 8'h00};
            ST_READ:  cmd_for = {1'b1, 16'h0062, 8'h00};
            ST_CLR:   cmd_for = {1'b0, 16'h0015, 8'h07};
            default:  cmd_for = 25'd0;
        endcase
    endfunction

`ifdef VL6180X_SEQ_INIT_EN
    function automatic logic [24:0] init_entry(input logic [2:0] i);
        case (i)
            3'd0:    init_entry = {1'b0, 16'h0207, 8'h01};
            3'd1:    init_entry = {1'b0, 16'h0208, 8'h01};
            3'd2:    init_entry = {1'b0, 16'h0096, 8'h00};
            3'd3:    init_entry = {1'b0, 16'h0097, 8'hFD};
            3'd4:    init_entry = {1'b0, 16'h00E3, 8'h00};
            3'd5:    init_entry = {1'b0, 16'h00E4, 8'h04};
            3'd6:    init_entry = {1'b0, 16'h00E5, 8'h02};
            default: init_entry = {1'b0, 16'h00E6, 8'h01};
        endcase
    endfunction

    logic [2:0] init_idx, init_idx_n;
`endif

    state_t             state, state_n;
    logic               cmd_valid, cmd_valid_n;
    logic               outstanding, outstanding_n;
    logic [6:0]         cmd_addr, cmd_addr_n;
    logic               cmd_rw, cmd_rw_n;
    logic [15:0]        cmd_reg, cmd_reg_n;
    logic [7:0]         cmd_wdata, cmd_wdata_n;
    logic [7:0]         range_q, range_n;
    logic               range_vld, range_vld_n;
    logic [POLL_W-1:0]  poll_cnt, poll_cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [ERR_W-1:0]   err_cnt, err_cnt_n;
    logic               go;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_BOOT;
            cmd_valid   <= 1'b0;
            outstanding <= 1'b0;
            cmd_addr    <= '0;
            cmd_rw      <= 1'b0;
            cmd_reg     <= '0;
            cmd_wdata   <= '0;
            range_q     <= '0;
            range_vld   <= 1'b0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            err_cnt     <= '0;
`ifdef VL6180X_SEQ_INIT_EN
            init_idx    <= '0;
`endif
        end else begin
            state       <= state_n;
            cmd_valid   <= cmd_valid_n;
            outstanding <= outstanding_n;
            cmd_addr    <= cmd_addr_n;
            cmd_rw      <= cmd_rw_n;
            cmd_reg     <= cmd_reg_n;
            cmd_wdata   <= cmd_wdata_n;
            range_q     <= range_n;
            range_vld   <= range_vld_n;
            poll_cnt    <= poll_cnt_n;
            gap_cnt     <= gap_cnt_n;
            err_cnt     <= err_cnt_n;
`ifdef VL6180X_SEQ_INIT_EN
            init_idx    <= init_idx_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        cmd_valid_n   = cmd_valid;
        outstanding_n = outstanding;
        cmd_addr_n    = cmd_addr;
        cmd_rw_n      = cmd_rw;
        cmd_reg_n     = cmd_reg;
        cmd_wdata_n   = cmd_wdata;
        range_n       = range_q;
        range_vld_n   = 1'b0;
        poll_cnt_n    = poll_cnt;
        gap_cnt_n     = gap_cnt;
        err_cnt_n     = err_cnt;
        go            = 1'b0;
`ifdef VL6180X_SEQ_INIT_EN
        init_idx_n    = init_idx;
`endif

        case (state)
            ST_GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    state_n = ST_START;
                    go      = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            ST_ERR: begin
                if (err_cnt >= ERR_LAST) begin
                    state_n = ST_BOOT;
                    go      = 1'b1;
                end else begin
                    err_cnt_n = err_cnt + ERR_W'(1);
                end
            end
            default: begin
                if (cmd_valid) begin
                    if (CMD_READY) begin
                        cmd_valid_n   = 1'b0;
                        outstanding_n = 1'b1;
                    end
                end else if (!outstanding) begin
                    // Only reachable right after reset: nothing issued yet.
                    go = 1'b1;
                end else if (RSP_VALID) begin
                    outstanding_n = 1'b0;
                    if (RSP_NACK) begin
                        state_n   = ST_ERR;
                        err_cnt_n = '0;
                    end else begin
                        go = 1'b1;
                        case (state)
                            ST_BOOT: begin
                                if (RSP_DATA[0]) begin
`ifdef VL6180X_SEQ_INIT_EN
                                    state_n    = ST_INIT;
                                    init_idx_n = '0;
`else
                                    state_n    = ST_CLRF;
`endif
                                end
                            end
`ifdef VL6180X_SEQ_INIT_EN
                            ST_INIT: begin
                                if (init_idx == 3'd7) state_n = ST_CLRF;
                                else                  init_idx_n = init_idx + 3'd1;
                            end
`endif
                            ST_CLRF:  state_n = ST_START;
                            ST_START: begin
                                state_n    = ST_POLL;
                                poll_cnt_n = '0;
                            end
                            ST_POLL: begin
                                if (RSP_DATA[2:0] == 3'd4) begin
                                    state_n = ST_READ;
                                end else if (poll_cnt >= POLL_LAST) begin
                                    state_n   = ST_ERR;
                                    err_cnt_n = '0;
                                    go        = 1'b0;
                                end else begin
                                    poll_cnt_n = poll_cnt + POLL_W'(1);
                                end
                            end
                            ST_READ: begin
                                range_n     = RSP_DATA;
                                range_vld_n = 1'b1;
                                state_n     = ST_CLR;
                            end
                            ST_CLR: begin
                                if (POLL_GAP == 0) begin
                                    state_n = ST_START;
                                end else begin
                                    state_n   = ST_GAP;
                                    gap_cnt_n = '0;
                                    go        = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        // The next command is presented in the same edge that enters its state.
        if (go) begin
            cmd_valid_n = 1'b1;
            cmd_addr_n  = DEV_ADDR;
`ifdef VL6180X_SEQ_INIT_EN
            if (state_n == ST_INIT) {cmd_rw_n, cmd_reg_n, cmd_wdata_n} = init_entry(init_idx_n);
            else                    {cmd_rw_n, cmd_reg_n, cmd_wdata_n} = cmd_for(state_n);
`else
            {cmd_rw_n, cmd_reg_n, cmd_wdata_n} = cmd_for(state_n);
`endif
        end
    end

    assign CMD_VALID   = cmd_valid;
    assign CMD_ADDR    = cmd_addr;
    assign CMD_RW      = cmd_rw;
    assign CMD_REG     = cmd_reg;
    assign CMD_WDATA   = cmd_wdata;
    assign RANGE       = range_q;
    assign RANGE_VALID = range_vld;
    assign ERROR       = (state == ST_ERR);

endmodule
